// File: rtl/mode_select_input.sv
// Speed/direction input conditioner: synchronizes and debounces a push-button and a slide switch,
// then drives a registered 3-bit LED pattern select code with a one-cycle change strobe.
// Optional auto-repeat of a held key is enabled by defining KEY_AUTOREPEAT_EN.
module mode_select_input #(
  parameter int DEB_WIDTH = 18,
  parameter int DEB_COUNT = 240000,
  parameter int RPT_WIDTH = 24,
  parameter int RPT_COUNT = 12000000
) (
  input  logic       CLK_In,
  input  logic       RST,
  input  logic       Key_In,
  input  logic       Dir_Sw,
  output logic [2:0] Ctrl_Out,
  output logic       Change_Pulse
);

  localparam logic [DEB_WIDTH-1:0] DEB_LAST = DEB_WIDTH'(DEB_COUNT - 1);

  if (DEB_COUNT < 1 || DEB_WIDTH < 1 || RPT_COUNT < 1 || RPT_WIDTH < 1) begin : g_cfg_bad
    $error("mode_select_input: counts and widths must be at least 1");
  end

  logic                 key_s1, key_s2, dir_s1, dir_s2;
  logic                 key_stable, dir_stable, key_prev;
  logic [DEB_WIDTH-1:0] key_cnt, dir_cnt;
  logic [1:0]           speed, speed_next;
  logic [2:0]           code_next;
  logic                 press, rpt_fire;

  // Key idles high (released), direction idles low (forward).
  always_ff @(posedge CLK_In) begin
    if (!RST) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      dir_s1 <= 1'b0;
      dir_s2 <= 1'b0;
    end else begin
      key_s1 <= Key_In;
      key_s2 <= key_s1;
      dir_s1 <= Dir_Sw;
      dir_s2 <= dir_s1;
    end
  end

  always_ff @(posedge CLK_In) begin
    if (!RST) begin
      key_stable <= 1'b1;
      key_cnt    <= '0;
    end else if (key_s2 == key_stable) begin
      key_cnt <= '0;
    end else if (key_cnt == DEB_LAST) begin
      key_stable <= key_s2;
      key_cnt    <= '0;
    end else begin
      key_cnt <= key_cnt + DEB_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK_In) begin
    if (!RST) begin
      dir_stable <= 1'b0;
      dir_cnt    <= '0;
    end else if (dir_s2 == dir_stable) begin
      dir_cnt <= '0;
    end else if (dir_cnt == DEB_LAST) begin
      dir_stable <= dir_s2;
      dir_cnt    <= '0;
    end else begin
      dir_cnt <= dir_cnt + DEB_WIDTH'(1);
    end
  end

  assign press = key_prev & ~key_stable;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [RPT_WIDTH-1:0] RPT_LAST = RPT_WIDTH'(RPT_COUNT - 1);
  logic [RPT_WIDTH-1:0] rpt_cnt;

  // Counting starts the cycle after the press step, so the first repeat lands RPT_COUNT cycles later.
  always_ff @(posedge CLK_In) begin
    if (!RST || key_stable || key_prev) begin
      rpt_cnt <= '0;
    end else if (rpt_cnt == RPT_LAST) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + RPT_WIDTH'(1);
    end
  end

  assign rpt_fire = ~key_stable & ~key_prev & (rpt_cnt == RPT_LAST);
`else
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    speed_next = speed;
    if (speed == 2'd3) begin
      speed_next = 2'd0;
    end else if (press || rpt_fire) begin
      speed_next = (speed == 2'd2) ? 2'd0 : speed + 2'd1;
    end
    code_next = {speed_next, dir_stable};
  end

  always_ff @(posedge CLK_In) begin
    if (!RST) begin
      speed        <= 2'd0;
      key_prev     <= 1'b1;
      Ctrl_Out     <= 3'b000;
      Change_Pulse <= 1'b0;
    end else begin
      speed        <= speed_next;
      key_prev     <= key_stable;
      Ctrl_Out     <= code_next;
      Change_Pulse <= (code_next != Ctrl_Out);
    end
  end

endmodule

// File: tb/tb_mode_select_input.sv
// Self-checking bench for mode_select_input: windowed-history reference model compared every cycle,
// plus directed sequences with literal expectations at the documented latency points.
module tb_mode_select_input;

  localparam int D = 8;
  localparam int R = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic       dir_sw;
  logic [2:0] ctrl_out;
  logic       change_pulse;

  int checks = 0;
  int errors = 0;

  mode_select_input #(
    .DEB_WIDTH(4),
    .DEB_COUNT(D),
    .RPT_WIDTH(6),
    .RPT_COUNT(R)
  ) dut (
    .CLK_In(clk),
    .RST(rst),
    .Key_In(key_in),
    .Dir_Sw(dir_sw),
    .Ctrl_Out(ctrl_out),
    .Change_Pulse(change_pulse)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: an input level is accepted once the last D synchronized samples all disagree
  // with the accepted level; the select code follows one edge after an accepted press or direction.
  bit         m_s1k, m_s2k, m_s1d, m_s2d, m_stk, m_std, m_press, m_valid, m_step;
  bit         win_k[$];
  bit         win_d[$];
  int         m_speed, m_hold;
  logic [2:0] m_code, m_new;
  logic       m_pulse;

  function automatic bit all_differ(input bit q[$], input bit v);
    foreach (q[i]) if (q[i] == v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_s1k = 1'b1; m_s2k = 1'b1; m_s1d = 1'b0; m_s2d = 1'b0;
      m_stk = 1'b1; m_std = 1'b0; m_press = 1'b0;
      win_k.delete(); win_d.delete();
      m_speed = 0; m_hold = 0; m_code = 3'd0; m_pulse = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_step = 1'b0;
      if (m_press) begin
        m_step = 1'b1;
        m_hold = 0;
      end else if (!m_stk) begin
        m_hold++;
`ifdef KEY_AUTOREPEAT_EN
        if (m_hold == R) begin
          m_step = 1'b1;
          m_hold = 0;
        end
`endif
      end else begin
        m_hold = 0;
      end
      if (m_step) m_speed = (m_speed + 1) % 3;
      m_new   = 3'(2 * m_speed + int'(m_std));
      m_pulse = (m_new != m_code);
      m_code  = m_new;

      win_k.push_back(m_s2k);
      if (win_k.size() > D) void'(win_k.pop_front());
      win_d.push_back(m_s2d);
      if (win_d.size() > D) void'(win_d.pop_front());
      m_press = 1'b0;
      if (win_k.size() == D && all_differ(win_k, m_stk)) begin
        m_stk   = ~m_stk;
        m_press = ~m_stk;
      end
      if (win_d.size() == D && all_differ(win_d, m_std)) m_std = ~m_std;

      m_s2k = m_s1k; m_s1k = key_in;
      m_s2d = m_s1d; m_s1d = dir_sw;
    end
  end

  // scoreboard: every cycle after the first reset edge
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (ctrl_out !== m_code) begin
        errors++;
        $display("FAIL model_code t=%0t got %0d want %0d", $time, ctrl_out, m_code);
      end
      checks++;
      if (change_pulse !== m_pulse) begin
        errors++;
        $display("FAIL model_pulse t=%0t got %0b want %0b", $time, change_pulse, m_pulse);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, want);
    end
  endtask

  // Inputs change at a negedge; the new code must appear after the 11th following rising edge.
  task automatic expect_step(input string name, input int old_code, input int new_code);
    tick(10);
    lit({name, "_before"}, int'(ctrl_out), old_code);
    lit({name, "_pulse_before"}, int'(change_pulse), 0);
    tick(1);
    lit({name, "_after"}, int'(ctrl_out), new_code);
    lit({name, "_pulse"}, int'(change_pulse), 1);
    tick(1);
    lit({name, "_pulse_end"}, int'(change_pulse), 0);
  endtask

  task automatic press_step(input string name, input int old_code, input int new_code);
    key_in = 1'b0;
    expect_step(name, old_code, new_code);
    tick(8);
    key_in = 1'b1;
    tick(15);
    lit({name, "_release"}, int'(ctrl_out), new_code);
  endtask

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT1 = 4;
  localparam int RPT2 = 0;
`else
  localparam int RPT1 = 2;
  localparam int RPT2 = 2;
`endif

  initial begin
    rst = 1'b0; key_in = 1'b0; dir_sw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      lit("reset_code", int'(ctrl_out), 0);
      lit("reset_pulse", int'(change_pulse), 0);
    end
    rst = 1'b1; key_in = 1'b1;
    tick(1);
    lit("post_reset_code", int'(ctrl_out), 0);
    lit("post_reset_pulse", int'(change_pulse), 0);
    tick(9);
    lit("dir_init_before", int'(ctrl_out), 0);
    tick(1);
    lit("dir_init_after", int'(ctrl_out), 1);
    lit("dir_init_pulse", int'(change_pulse), 1);
    tick(1);
    lit("dir_init_pulse_end", int'(change_pulse), 0);

    dir_sw = 1'b0;
    tick(15);
    lit("fwd_code", int'(ctrl_out), 0);

    press_step("press1", 0, 2);
    press_step("press2", 2, 4);
    press_step("press3", 4, 0);

    for (int i = 0; i < 10; i++) begin
      key_in = (i % 2 == 0) ? 1'b0 : 1'b1;
      tick(3);
    end
    lit("bounce_no_step", int'(ctrl_out), 0);
    key_in = 1'b0;
    expect_step("bounce", 0, 2);
    tick(8);
    key_in = 1'b1;
    tick(15);

    key_in = 1'b0;
    tick(7);
    key_in = 1'b1;
    tick(20);
    lit("glitch_code", int'(ctrl_out), 2);

    press_step("to4", 2, 4);
    dir_sw = 1'b1;
    expect_step("dir_rev", 4, 5);
    tick(10);
    press_step("wrap_rev", 5, 1);

    dir_sw = 1'b0;
    tick(15);
    lit("back_to_0", int'(ctrl_out), 0);
    key_in = 1'b0; dir_sw = 1'b1;
    expect_step("simul", 0, 3);
    tick(8);
    key_in = 1'b1;
    tick(15);
    lit("simul_hold", int'(ctrl_out), 3);

    dir_sw = 1'b0;
    tick(15);
    press_step("pre_rpt_a", 2, 4);
    press_step("pre_rpt_b", 4, 0);
    key_in = 1'b0;
    tick(11);
    lit("hold_first", int'(ctrl_out), 2);
    tick(32);
    lit("hold_rpt1", int'(ctrl_out), RPT1);
    tick(32);
    lit("hold_rpt2", int'(ctrl_out), RPT2);
    tick(5);
    key_in = 1'b1;
    tick(20);
    lit("hold_released", int'(ctrl_out), RPT2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mode_select_input.md
Name: mode_select_input

Overview:
Input-side conditioner that generates the 3-bit LED pattern select code consumed by the LED pattern multiplexer. It takes one raw push-button (speed step) and one raw slide switch (direction). Both inputs are synchronized and debounced. The block then drives a registered select code and a one-cycle change strobe. It replaces direct DIP-switch wiring of the select code at the top level.

Parameters:
- DEB_WIDTH, 18, width of each debounce counter; must hold DEB_COUNT-1.
- DEB_COUNT, 240000, consecutive cycles an input must differ from its stable value before it is accepted (20 ms at 12 MHz).
- RPT_WIDTH, 24, width of the auto-repeat counter; used only with KEY_AUTOREPEAT_EN.
- RPT_COUNT, 12000000, hold cycles per auto-repeat step; used only with KEY_AUTOREPEAT_EN.

Ports:
- CLK_In, input, 1, system clock; the only clock in the block.
- RST, input, 1, reset; synchronous, active-low.
- Key_In, input, 1, raw push-button, asynchronous and bouncy; 0 = pressed.
- Dir_Sw, input, 1, raw direction switch, asynchronous and bouncy; 0 = forward, 1 = reverse.
- Ctrl_Out, output, 3, registered select code.
- Change_Pulse, output, 1, high for exactly one cycle in the cycle Ctrl_Out takes a new value.

Behaviour:
- Reset (RST=0 at a CLK_In rising edge):
  - key synchronizer flops = 1; dir synchronizer flops = 0
  - key_stable = 1; dir_stable = 0
  - both debounce counters = 0
  - speed index = 0
  - Ctrl_Out = 3'b000; Change_Pulse = 0
- Reset mid-debounce or mid-repeat discards all partial counts.
- Synchronizer: two flops per raw input. Edge 1 samples into s1, edge 2 into s2.
- Debounce, applied to each input independently:
  - s2 == stable: counter cleared to 0.
  - s2 != stable and counter < DEB_COUNT-1: counter increments.
  - s2 != stable and counter == DEB_COUNT-1: stable <= s2; counter cleared.
  - Any glitch shorter than DEB_COUNT cycles restarts the count and produces no output change.
- Events:
  - press = key_stable goes 1->0.
  - Release (0->1) has no effect.
  - Holding the key gives exactly one step (unless KEY_AUTOREPEAT_EN).
- Speed index: 2-bit, sequence 0 -> 1 -> 2 -> 0 on each press. Value 3 is unreachable; if ever present it returns to 0 on the next cycle.
- Encoding: Ctrl_Out = 2*speed + dir_stable.
  - 0 = 2 Hz fwd, 1 = 2 Hz rev
  - 2 = 5 Hz fwd, 3 = 5 Hz rev
  - 4 = 11 Hz fwd, 5 = 11 Hz rev
  - Codes 6 and 7 are never driven.
- Latency:
  - Stable value updates at edge DEB_COUNT+2, counting from the first edge that samples the new raw level.
  - Speed index, Ctrl_Out and Change_Pulse update at edge DEB_COUNT+3.
- Change_Pulse:
  - Asserted in exactly the cycle Ctrl_Out differs from its previous value.
  - Never asserted when the value is unchanged.
  - Never high for two consecutive cycles from a single event.
- Simultaneous press and direction change accepted in the same cycle: both apply in one Ctrl_Out update with a single Change_Pulse.
- Wrap: from code 4 or 5 a press yields 0 or 1 (direction preserved).

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - While key_stable = 0, a repeat counter (RPT_WIDTH bits) runs.
  - Each time it reaches RPT_COUNT-1 it clears and generates one extra press step, with Change_Pulse.
  - Counter cleared whenever key_stable = 1 and on reset.
  - The first step still comes from the press edge; the first repeat occurs RPT_COUNT cycles after it.
- Undefined: no repeat counter is instantiated; a held key gives exactly one step. RPT_* parameters are unused.

Test Plan:
- Use DEB_COUNT=8 and RPT_COUNT=32 for simulation.
- Reset: RST low for 3 cycles with Key_In=0, Dir_Sw=1 -> Ctrl_Out=0 and Change_Pulse=0 during and one cycle after reset. Then Dir_Sw=1 accepted -> Ctrl_Out=1 at edge 11 after release, with one pulse.
- Clean press: Key_In 1->0 held 20 cycles -> Ctrl_Out 0->2 at edge 11 after the edge, one pulse. Three total presses -> 2, 4, 0.
- Bounce: Key_In toggled every 3 cycles for 30 cycles, then held 0 -> exactly one step, occurring 11 edges after the final settle. Glitch of 7 cycles -> no change.
- Direction: at code 4, Dir_Sw 0->1 -> Ctrl_Out=5 with one pulse. A press then gives 1.
- Simultaneous: Key_In and Dir_Sw change on the same edge from code 0 -> Ctrl_Out=3 with exactly one pulse.
- KEY_AUTOREPEAT_EN: key held 80 cycles from code 0 -> 2 at the press, then 4 and 0 at 32-cycle intervals. Without the macro -> stays 2.
